alu_seq: RTL and testbench

- Parametrised, sequential successor to the 8-bit combinational ALU.
- Same opcode set, generalised to WIDTH bits, plus iterative multiply.
- Operand/result transfer uses valid/ready handshakes; shifts and multiply take multiple cycles.
- Sits between the decode stage and the register-file writeback / branch unit; all results are registered.

---
 rtl/alu_seq_if.sv | 27 ++
 rtl/alu_seq.sv | 191 +++++++++++++++++++
 tb/tb_alu_seq.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
// Operation/result handshake bundle between decode and alu_seq.
interface alu_seq_if #(
  parameter int WIDTH = 8
);
  logic             in_valid_i;
  logic             in_ready_o;
  logic [3:0]       inst_i;
  logic [WIDTH-1:0] reg1_i;
  logic [WIDTH-1:0] reg2_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [WIDTH-1:0] reg_o;
  logic [WIDTH-1:0] over_o;
  logic             over_flag;
  logic             branch_o;
  logic             err_o;

  modport master (
    output in_valid_i, inst_i, reg1_i, reg2_i, out_ready_i,
    input  in_ready_o, out_valid_o, reg_o, over_o, over_flag, branch_o, err_o
  );

  modport slave (
    input  in_valid_i, inst_i, reg1_i, reg2_i, out_ready_i,
    output in_ready_o, out_valid_o, reg_o, over_o, over_flag, branch_o, err_o
  );
endinterface

// File: rtl/alu_seq.sv
// Sequential WIDTH-bit ALU: 1-cycle ops, bit-serial shifts, shift-add MUL (built only with ALU_MUL_EN).
// Accepts only in IDLE; result is held in DONE until out_ready_i, so the consumer can stall indefinitely.
module alu_seq #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH) + 1
) (
  input logic      clk_i,
  input logic      rst_n_i,
  alu_seq_if.slave bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_SFL = 4'b0010;
  localparam logic [3:0] OP_SFR = 4'b0011;
  localparam logic [3:0] OP_INC = 4'b0100;
  localparam logic [3:0] OP_DEC = 4'b0101;
  localparam logic [3:0] OP_BNE = 4'b0110;
  localparam logic [3:0] OP_BEQ = 4'b0111;
  localparam logic [3:0] OP_BLT = 4'b1000;
  localparam logic [3:0] OP_LHB = 4'b1001;
  localparam logic [3:0] OP_JMP = 4'b1010;
  localparam logic [3:0] OP_MUL = 4'b1011;

  localparam logic [SHW-1:0]   CNT_W    = SHW'(WIDTH);
  localparam logic [WIDTH-1:0] WIDTH_B  = WIDTH'(WIDTH);
  localparam logic [WIDTH-1:0] LHB_MASK = {{(WIDTH/2){1'b1}}, {(WIDTH/2){1'b0}}};

  logic [1:0]       state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q, res_d, ovr_q, ovr_d;
  logic             flag_q, flag_d, br_q, br_d, err_q, err_d;

  logic [WIDTH:0]   sum, diff;
  logic [WIDTH-1:0] shifted;

  assign sum     = {1'b0, a_q} + {1'b0, b_q};
  assign diff    = {1'b0, a_q} - {1'b0, b_q};
  assign shifted = (op_q == OP_SFL) ? {a_q[WIDTH-2:0], 1'b0} : {1'b0, a_q[WIDTH-1:1]};

`ifdef ALU_MUL_EN
  // Product accumulates as {hi_q, b_q}; the multiplier drains out of b_q's LSB.
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi, mul_lo;

  assign mul_sum = {1'b0, hi_q} + (b_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
  assign mul_hi  = mul_sum[WIDTH:1];
  assign mul_lo  = {mul_sum[0], b_q[WIDTH-1:1]};
`endif

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    ovr_d   = ovr_q;
    flag_d  = flag_q;
    br_d    = br_q;
    err_d   = err_q;
`ifdef ALU_MUL_EN
    hi_d    = hi_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid_i) begin
          state_d = S_EXEC;
          op_d    = bus.inst_i;
          a_d     = bus.reg1_i;
          b_d     = bus.reg2_i;
          cnt_d   = (bus.inst_i == OP_MUL || bus.reg2_i >= WIDTH_B) ? CNT_W : bus.reg2_i[SHW-1:0];
`ifdef ALU_MUL_EN
          hi_d    = '0;
`endif
        end
      end
      S_EXEC: begin
        state_d = S_DONE;
        case (op_q)
          OP_ADD: begin
            res_d  = sum[WIDTH-1:0];
            flag_d = sum[WIDTH];
            ovr_d  = {{(WIDTH-1){1'b0}}, sum[WIDTH]};
          end
          OP_SUB: begin
            res_d  = diff[WIDTH-1:0];
            flag_d = diff[WIDTH];
          end
          OP_INC: begin
            res_d  = a_q + 1'b1;
            flag_d = &a_q;
          end
          OP_DEC: begin
            res_d  = a_q - 1'b1;
            flag_d = ~|a_q;
          end
          OP_SFL, OP_SFR: begin
            // A zero count still spends one EXEC cycle and returns A untouched.
            if (cnt_q == '0) begin
              res_d = a_q;
            end else if (cnt_q == SHW'(1)) begin
              res_d = shifted;
            end else begin
              state_d = S_EXEC;
              a_d     = shifted;
              cnt_d   = cnt_q - 1'b1;
            end
          end
          OP_BNE: br_d  = (a_q != b_q);
          OP_BEQ: br_d  = (a_q == b_q);
          OP_BLT: br_d  = (a_q < b_q);
          OP_LHB: res_d = a_q & LHB_MASK;
          OP_JMP: br_d  = 1'b1;
`ifdef ALU_MUL_EN
          OP_MUL: begin
            if (cnt_q == SHW'(1)) begin
              res_d  = mul_lo;
              ovr_d  = mul_hi;
              flag_d = |mul_hi;
            end else begin
              state_d = S_EXEC;
              hi_d    = mul_hi;
              b_d     = mul_lo;
              cnt_d   = cnt_q - 1'b1;
            end
          end
`endif
          default: err_d = 1'b1;
        endcase
      end
      S_DONE: begin
        if (bus.out_ready_i) begin
          state_d = S_IDLE;
          res_d   = '0;
          ovr_d   = '0;
          flag_d  = 1'b0;
          br_d    = 1'b0;
          err_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      ovr_q   <= '0;
      flag_q  <= 1'b0;
      br_q    <= 1'b0;
      err_q   <= 1'b0;
`ifdef ALU_MUL_EN
      hi_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      ovr_q   <= ovr_d;
      flag_q  <= flag_d;
      br_q    <= br_d;
      err_q   <= err_d;
`ifdef ALU_MUL_EN
      hi_q    <= hi_d;
`endif
    end
  end

  assign bus.in_ready_o  = (state_q == S_IDLE);
  assign bus.out_valid_o = (state_q == S_DONE);
  assign bus.reg_o       = res_q;
  assign bus.over_o      = ovr_q;
  assign bus.over_flag   = flag_q;
  assign bus.branch_o    = br_q;
  assign bus.err_o       = err_q;
endmodule

// File: tb/tb_alu_seq.sv
// Randomized bench for alu_seq against a transaction-level reference model, plus directed literal cases.
module tb_alu_seq;
  typedef struct packed {
    logic [7:0] res;
    logic [7:0] ovr;
    logic       flag;
    logic       br;
    logic       err;
  } res_t;

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  alu_seq_if #(.WIDTH(8))  bus();
  alu_seq_if #(.WIDTH(16)) bus16();

  alu_seq #(.WIDTH(8))  dut   (.clk_i(clk), .rst_n_i(rst_n), .bus(bus));
  alu_seq #(.WIDTH(16)) dut16 (.clk_i(clk), .rst_n_i(rst_n), .bus(bus16));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic res_t dut_vec();
    res_t r;
    r.res  = bus.reg_o;
    r.ovr  = bus.over_o;
    r.flag = bus.over_flag;
    r.br   = bus.branch_o;
    r.err  = bus.err_o;
    return r;
  endfunction

  // Reference: what the operation must produce and how many cycles it takes.
  function automatic res_t model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                                 output int lat);
    res_t r;
    int   s;
    int   n;
    r   = '0;
    lat = 1;
    n   = (int'(b) > 8) ? 8 : int'(b);
    case (op)
      4'd0: begin s = int'(a) + int'(b); r.res = s[7:0]; r.flag = s[8]; r.ovr = {7'd0, s[8]}; end
      4'd1: begin r.res = a - b; r.flag = (a < b); end
      4'd2: begin lat = (n == 0) ? 1 : n; r.res = (n >= 8) ? 8'd0 : 8'(a << n); end
      4'd3: begin lat = (n == 0) ? 1 : n; r.res = (n >= 8) ? 8'd0 : 8'(a >> n); end
      4'd4: begin r.res = a + 8'd1; r.flag = (a == 8'hFF); end
      4'd5: begin r.res = a - 8'd1; r.flag = (a == 8'h00); end
      4'd6: r.br = (a != b);
      4'd7: r.br = (a == b);
      4'd8: r.br = (a < b);
      4'd9: r.res = a & 8'hF0;
      4'd10: r.br = 1'b1;
`ifdef ALU_MUL_EN
      4'd11: begin s = int'(a) * int'(b); r.res = s[7:0]; r.ovr = s[15:8]; r.flag = (s[15:8] != 8'd0); lat = 8; end
`endif
      default: r.err = 1'b1;
    endcase
    return r;
  endfunction

  // Cycle-level expectation: idle, in flight for lat cycles, then holding the result.
  bit   mon_en = 1'b0;
  bit   m_busy = 1'b0;
  bit   m_done = 1'b0;
  int   m_left = 0;
  res_t m_exp  = '0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_busy = 1'b0;
      m_done = 1'b0;
    end else if (m_done) begin
      if (bus.out_ready_i) begin
        m_busy = 1'b0;
        m_done = 1'b0;
      end
    end else if (m_busy) begin
      m_left--;
      if (m_left <= 0) m_done = 1'b1;
    end else if (bus.in_valid_i) begin
      m_busy = 1'b1;
      m_exp  = model(bus.inst_i, bus.reg1_i, bus.reg2_i, m_left);
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      chk("handshake", 64'({bus.in_ready_o, bus.out_valid_o}), 64'({~m_busy, m_done}));
      if (m_done) chk("result", 64'(dut_vec()), 64'(m_exp));
    end
  end

  task automatic scramble();
    bus.in_valid_i = 1'($urandom);
    bus.inst_i     = 4'($urandom);
    bus.reg1_i     = 8'($urandom);
    bus.reg2_i     = 8'($urandom);
  endtask

  // Issue one op from IDLE, stall the result for hold cycles, return what the DUT showed.
  task automatic run_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        input int hold, output res_t got, output int lat);
    bus.in_valid_i  = 1'b1;
    bus.inst_i      = op;
    bus.reg1_i      = a;
    bus.reg2_i      = b;
    bus.out_ready_i = (hold == 0);
    @(posedge clk); #1;
    lat = 0;
    do begin
      scramble();
      @(posedge clk); #1;
      lat++;
    end while (!bus.out_valid_o && lat < 200);
    if (!bus.out_valid_o) chk("timeout", 64'(0), 64'(1));
    got = dut_vec();
    for (int i = 0; i < hold; i++) begin
      scramble();
      @(posedge clk); #1;
    end
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic run16(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                       output logic [17:0] got, output int lat);
    bus16.in_valid_i  = 1'b1;
    bus16.inst_i      = op;
    bus16.reg1_i      = a;
    bus16.reg2_i      = b;
    bus16.out_ready_i = 1'b1;
    @(posedge clk); #1;
    bus16.in_valid_i = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!bus16.out_valid_o && lat < 200);
    got = {bus16.reg_o, bus16.branch_o, bus16.err_o};
    @(posedge clk); #1;
  endtask

  initial begin
    res_t        got;
    res_t        exp;
    int          lat;
    int          elat;
    logic [3:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [17:0] g16;

    rst_n = 1'b0;
    bus.in_valid_i = 1'b0;   bus.inst_i = '0;   bus.reg1_i = '0;   bus.reg2_i = '0;   bus.out_ready_i = 1'b0;
    bus16.in_valid_i = 1'b0; bus16.inst_i = '0; bus16.reg1_i = '0; bus16.reg2_i = '0; bus16.out_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", 64'({bus.in_ready_o, bus.out_valid_o, dut_vec()}), 64'({1'b1, 1'b0, 19'd0}));
    mon_en = 1'b1;
    rst_n  = 1'b1;

    run_op(4'd0, 8'hF0, 8'h20, 0, got, lat);
    chk("add_res", 64'(got), 64'({8'h10, 8'h01, 1'b1, 1'b0, 1'b0}));
    chk("add_lat", 64'(lat), 64'(1));
    chk("add_ready_next", 64'(bus.in_ready_o), 64'(1));

    run_op(4'd2, 8'h01, 8'd3, 0, got, lat);
    chk("sfl3_res", 64'(got.res), 64'(8'h08));
    chk("sfl3_lat", 64'(lat), 64'(3));
    run_op(4'd3, 8'h80, 8'd9, 0, got, lat);
    chk("sfr9_res", 64'(got.res), 64'(8'h00));
    chk("sfr9_lat", 64'(lat), 64'(8));
    run_op(4'd2, 8'h5A, 8'd0, 0, got, lat);
    chk("sfl0_res", 64'(got.res), 64'(8'h5A));
    chk("sfl0_lat", 64'(lat), 64'(1));

    run_op(4'd11, 8'hFF, 8'hFF, 0, got, lat);
`ifdef ALU_MUL_EN
    chk("mul_res", 64'(got), 64'({8'h01, 8'hFE, 1'b1, 1'b0, 1'b0}));
    chk("mul_lat", 64'(lat), 64'(8));
`else
    chk("mul_illegal", 64'(got), 64'({8'h00, 8'h00, 1'b0, 1'b0, 1'b1}));
    chk("mul_illegal_lat", 64'(lat), 64'(1));
`endif

    run_op(4'd8, 8'd3, 8'd5, 4, got, lat);
    chk("blt_hold", 64'(got), 64'({8'h00, 8'h00, 1'b0, 1'b1, 1'b0}));

    // Reset in the third EXEC cycle of a MUL discards it.
    bus.in_valid_i = 1'b1; bus.inst_i = 4'd11; bus.reg1_i = 8'hFF; bus.reg2_i = 8'hFF; bus.out_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.in_valid_i = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mid_reset", 64'({bus.in_ready_o, bus.out_valid_o, dut_vec()}), 64'({1'b1, 1'b0, 19'd0}));
    rst_n = 1'b1;
    run_op(4'd5, 8'h00, 8'h00, 0, got, lat);
    chk("dec_zero", 64'(got), 64'({8'hFF, 8'h00, 1'b1, 1'b0, 1'b0}));

    run16(4'd9, 16'hABCD, 16'h1234, g16, lat);
    chk("w16_lhb", 64'(g16), 64'({16'hAB00, 1'b0, 1'b0}));
    chk("w16_lhb_lat", 64'(lat), 64'(1));
    run16(4'd15, 16'hFFFF, 16'h0001, g16, lat);
    chk("w16_illegal", 64'(g16), 64'({16'h0000, 1'b0, 1'b1}));

    for (int i = 0; i < 150; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = 8'($urandom);
      b  = (op == 4'd2 || op == 4'd3) ? 8'($urandom_range(0, 12)) : 8'($urandom);
      if (i % 10 == 0) a = (i % 20 == 0) ? 8'hFF : 8'h00;
      exp = model(op, a, b, elat);
      run_op(op, a, b, int'($urandom_range(0, 3)), got, lat);
      chk("rand_res", 64'(got), 64'(exp));
      chk("rand_lat", 64'(lat), 64'(elat));
    end

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
